// File: rtl/regfile_bist_ctrl_if.sv
// Regfile access bundle: processor-side request signals, muxed regfile-side
// control/data, and the regfile's combinational read data.
interface regfile_bist_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();

  logic              p_ctrl_writeEnable;
  logic [ADDR_W-1:0] p_ctrl_writeReg;
  logic [ADDR_W-1:0] p_ctrl_readRegA;
  logic [ADDR_W-1:0] p_ctrl_readRegB;
  logic [DATA_W-1:0] p_data_writeReg;

  logic              r_ctrl_writeEnable;
  logic [ADDR_W-1:0] r_ctrl_writeReg;
  logic [ADDR_W-1:0] r_ctrl_readRegA;
  logic [ADDR_W-1:0] r_ctrl_readRegB;
  logic [DATA_W-1:0] r_data_writeReg;

  logic [DATA_W-1:0] r_data_readRegA;
  logic [DATA_W-1:0] r_data_readRegB;

  // System side: processor requests plus regfile read data.
  modport master (
    output p_ctrl_writeEnable, p_ctrl_writeReg, p_ctrl_readRegA, p_ctrl_readRegB,
    output p_data_writeReg,
    output r_data_readRegA, r_data_readRegB,
    input  r_ctrl_writeEnable, r_ctrl_writeReg, r_ctrl_readRegA, r_ctrl_readRegB,
    input  r_data_writeReg
  );

  // Controller side: owns the muxed regfile port.
  modport slave (
    input  p_ctrl_writeEnable, p_ctrl_writeReg, p_ctrl_readRegA, p_ctrl_readRegB,
    input  p_data_writeReg,
    input  r_data_readRegA, r_data_readRegB,
    output r_ctrl_writeEnable, r_ctrl_writeReg, r_ctrl_readRegA, r_ctrl_readRegB,
    output r_data_writeReg
  );

endinterface

// File: rtl/regfile_bist_ctrl.sv
// Regfile BIST controller: passes processor traffic through when idle, otherwise
// owns the regfile and runs a two-pass write/read-back march with error logging.
module regfile_bist_ctrl #(
  parameter int unsigned       NUM_REGS = 32,
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] PATTERN  = DATA_W'(32'hA5A5_5A5A)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  regfile_bist_ctrl_if.slave rf,
  output logic               proc_stall,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_W-1:0]  fail_reg,
  output logic [5:0]         err_count
);

  localparam int unsigned       ERR_W    = 6;
  localparam int unsigned       SUM_W    = ERR_W + 1;
  localparam int unsigned       ERR_MAX  = (1 << ERR_W) - 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic               pass_sel_q, pass_sel_d;
  logic               done_q;
  logic               pass_q, pass_d;
  logic [ADDR_W-1:0]  fail_reg_q, fail_reg_d;
  logic               fail_seen_q, fail_seen_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               bist_we;
  logic [ADDR_W-1:0]  bist_wr;
  logic [DATA_W-1:0]  bist_wd;
  logic [ADDR_W-1:0]  bist_ra;
  logic [ADDR_W-1:0]  bist_rb;
  logic [ADDR_W-1:0]  idx_b;
  logic               miss_a;
  logic               miss_b;
  logic [SUM_W-1:0]   err_sum;

  // Pattern written to register i; $0 gets the full pattern too.
  function automatic logic [DATA_W-1:0] write_pat(input logic sel,
                                                  input logic [ADDR_W-1:0] i);
    return (sel ? ~PATTERN : PATTERN) ^ DATA_W'(i);
  endfunction

  // Value register i must read back; $0 is hardwired to zero.
  function automatic logic [DATA_W-1:0] read_exp(input logic sel,
                                                 input logic [ADDR_W-1:0] i);
    return (i == '0) ? '0 : write_pat(sel, i);
  endfunction

  assign idx_b = LAST_IDX - idx_q;

  // Next-state, march sequencing and result bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_sel_d  = pass_sel_q;
    pass_d      = pass_q;
    fail_reg_d  = fail_reg_q;
    fail_seen_d = fail_seen_q;
    err_d       = err_q;
    bist_we     = 1'b0;
    bist_wr     = '0;
    bist_wd     = '0;
    bist_ra     = '0;
    bist_rb     = '0;
    miss_a      = 1'b0;
    miss_b      = 1'b0;
    err_sum     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WRITE;
          idx_d       = '0;
          pass_sel_d  = 1'b0;
          err_d       = '0;
          fail_reg_d  = '0;
          fail_seen_d = 1'b0;
        end
      end

      S_WRITE: begin
        bist_we = 1'b1;
        bist_wr = idx_q;
        bist_wd = write_pat(pass_sel_q, idx_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        bist_ra = idx_q;
        bist_rb = idx_b;
        miss_a  = (rf.r_data_readRegA != read_exp(pass_sel_q, idx_q));
        miss_b  = (rf.r_data_readRegB != read_exp(pass_sel_q, idx_b));
        err_sum = SUM_W'(err_q) + SUM_W'(miss_a) + SUM_W'(miss_b);
        err_d   = (err_sum > SUM_W'(ERR_MAX)) ? ERR_W'(ERR_MAX) : err_sum[ERR_W-1:0];
        // Port A takes priority when both ports miss in the same cycle.
        if (!fail_seen_q && (miss_a || miss_b)) begin
          fail_seen_d = 1'b1;
          fail_reg_d  = miss_a ? idx_q : idx_b;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (pass_sel_q) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0);
          end else begin
            state_d    = S_WRITE;
            pass_sel_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pass_sel_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_reg_q  <= '0;
      fail_seen_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_sel_q  <= pass_sel_d;
      done_q      <= (state_d == S_DONE);
      pass_q      <= pass_d;
      fail_reg_q  <= fail_reg_d;
      fail_seen_q <= fail_seen_d;
      err_q       <= err_d;
    end
  end

  // Port mux keyed only on the state register, so a reset hands the port back at once.
  always_comb begin
    if (state_q == S_IDLE) begin
      rf.r_ctrl_writeEnable = rf.p_ctrl_writeEnable;
      rf.r_ctrl_writeReg    = rf.p_ctrl_writeReg;
      rf.r_ctrl_readRegA    = rf.p_ctrl_readRegA;
      rf.r_ctrl_readRegB    = rf.p_ctrl_readRegB;
      rf.r_data_writeReg    = rf.p_data_writeReg;
    end else begin
      rf.r_ctrl_writeEnable = bist_we;
      rf.r_ctrl_writeReg    = bist_wr;
      rf.r_ctrl_readRegA    = bist_ra;
      rf.r_ctrl_readRegB    = bist_rb;
      rf.r_data_writeReg    = bist_wd;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign proc_stall = (state_q != S_IDLE);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_reg   = fail_reg_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Bench for regfile_bist_ctrl: faulty regfile model, per-cycle behavioural
// reference, directed scenarios and randomized fault/start/reset runs.
module tb_regfile_bist_ctrl;

  localparam int          NUM_REGS = 32;
  localparam int          ADDR_W   = 5;
  localparam int          DATA_W   = 32;
  localparam logic [31:0] PAT      = 32'hA5A5_5A5A;
  localparam int          TEST_LEN = 4 * NUM_REGS;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              proc_stall;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] fail_reg;
  logic [5:0]        err_count;

  regfile_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rf ();

  regfile_bist_ctrl #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .PATTERN (PAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .rf        (rf),
    .proc_stall(proc_stall),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_reg  (fail_reg),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  // Regfile with injectable stuck-at faults and an all-zero read mode.
  logic [31:0] rf_mem [NUM_REGS];
  logic [31:0] stuck1 [NUM_REGS];
  logic [31:0] stuck0 [NUM_REGS];
  bit          zero_rd;

  function automatic logic [31:0] rd_val(input int i, input logic [31:0] v,
                                         input logic [31:0] s1, input logic [31:0] s0,
                                         input bit z);
    if (i == 0 || z) return 32'h0;
    return (v | s1) & ~s0;
  endfunction

  assign rf.r_data_readRegA = rd_val(int'(rf.r_ctrl_readRegA), rf_mem[rf.r_ctrl_readRegA],
                                     stuck1[rf.r_ctrl_readRegA], stuck0[rf.r_ctrl_readRegA], zero_rd);
  assign rf.r_data_readRegB = rd_val(int'(rf.r_ctrl_readRegB), rf_mem[rf.r_ctrl_readRegB],
                                     stuck1[rf.r_ctrl_readRegB], stuck0[rf.r_ctrl_readRegB], zero_rd);

  always @(posedge clock) begin
    if (rf.r_ctrl_writeEnable) rf_mem[rf.r_ctrl_writeReg] <= rf.r_data_writeReg;
  end

  // Whole-test outcome from the march rules: both passes, both ports per read cycle.
  function automatic void expect_result(output int err, output int freg, output bit ok);
    bit          seen;
    int          j;
    logic [31:0] base, ea, eb, ga, gb;
    bit          ma, mb;
    seen = 1'b0;
    err  = 0;
    freg = 0;
    for (int p = 0; p < 2; p++) begin
      base = (p == 0) ? PAT : ~PAT;
      for (int i = 0; i < NUM_REGS; i++) begin
        j  = NUM_REGS - 1 - i;
        ga = rd_val(i, base ^ 32'(i), stuck1[i], stuck0[i], zero_rd);
        gb = rd_val(j, base ^ 32'(j), stuck1[j], stuck0[j], zero_rd);
        ea = (i == 0) ? 32'h0 : base ^ 32'(i);
        eb = (j == 0) ? 32'h0 : base ^ 32'(j);
        ma = (ga != ea);
        mb = (gb != eb);
        err += int'(ma) + int'(mb);
        if (!seen && (ma || mb)) begin
          seen = 1'b1;
          freg = ma ? i : j;
        end
      end
    end
    if (err > 63) err = 63;
    ok = (err == 0);
  endfunction

  // Reference: mk = cycles into the current test (-1 idle, TEST_LEN = done cycle).
  int mk = -1;
  bit mvalid = 1'b0;
  bit m_pass;
  int m_err;
  int m_fail;

  always @(posedge clock) begin
    if (reset) begin
      mvalid = 1'b1;
      mk     = -1;
      m_pass = 1'b0;
      m_err  = 0;
      m_fail = 0;
    end else if (mk < 0) begin
      if (start) begin
        mk     = 0;
        m_err  = 0;
        m_fail = 0;
      end
    end else if (mk == TEST_LEN) begin
      mk = -1;
    end else begin
      mk++;
      if (mk == TEST_LEN) expect_result(m_err, m_fail, m_pass);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  int          c_ph;
  int          c_idx;
  logic [31:0] c_base;

  always @(negedge clock) begin
    if (mvalid) begin
      chk("busy", 32'(busy), 32'(mk >= 0));
      chk("proc_stall", 32'(proc_stall), 32'(mk >= 0));
      chk("done", 32'(done), 32'(mk == TEST_LEN));
      if (mk < 0) begin
        chk("thru_we", 32'(rf.r_ctrl_writeEnable), 32'(rf.p_ctrl_writeEnable));
        chk("thru_wr", 32'(rf.r_ctrl_writeReg), 32'(rf.p_ctrl_writeReg));
        chk("thru_ra", 32'(rf.r_ctrl_readRegA), 32'(rf.p_ctrl_readRegA));
        chk("thru_rb", 32'(rf.r_ctrl_readRegB), 32'(rf.p_ctrl_readRegB));
        chk("thru_wd", rf.r_data_writeReg, rf.p_data_writeReg);
      end else if (mk < TEST_LEN) begin
        c_ph   = mk / NUM_REGS;
        c_idx  = mk % NUM_REGS;
        c_base = (c_ph >= 2) ? ~PAT : PAT;
        if (c_ph % 2 == 0) begin
          chk("bist_we", 32'(rf.r_ctrl_writeEnable), 32'd1);
          chk("bist_wr", 32'(rf.r_ctrl_writeReg), 32'(c_idx));
          chk("bist_wd", rf.r_data_writeReg, c_base ^ 32'(c_idx));
        end else begin
          chk("bist_rd_we", 32'(rf.r_ctrl_writeEnable), 32'd0);
          chk("bist_ra", 32'(rf.r_ctrl_readRegA), 32'(c_idx));
          chk("bist_rb", 32'(rf.r_ctrl_readRegB), 32'(NUM_REGS - 1 - c_idx));
        end
      end else begin
        chk("done_we", 32'(rf.r_ctrl_writeEnable), 32'd0);
      end
      if (mk < 0 || mk == TEST_LEN) begin
        chk("pass", 32'(pass), 32'(m_pass));
        chk("err_count", 32'(err_count), 32'(m_err));
        chk("fail_reg", 32'(fail_reg), 32'(m_fail));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    rf.p_ctrl_writeEnable = 1'($urandom);
    rf.p_ctrl_writeReg    = ADDR_W'($urandom);
    rf.p_ctrl_readRegA    = ADDR_W'($urandom);
    rf.p_ctrl_readRegB    = ADDR_W'($urandom);
    rf.p_data_writeReg    = $urandom;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < NUM_REGS; i++) begin
      stuck1[i] = 32'h0;
      stuck0[i] = 32'h0;
    end
    zero_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      cyc();
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Pulses start, returns start-to-done latency, busy after one cycle, and the
  // first write data seen for register 3.
  task automatic run_test(output int lat, output bit busy1, output logic [31:0] w3);
    bit got;
    got   = 1'b0;
    w3    = 32'h0;
    lat   = -1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    busy1 = busy;
    for (int n = 1; n <= 300; n++) begin
      if (!got && busy && rf.r_ctrl_writeEnable && rf.r_ctrl_writeReg == 5'd3) begin
        got = 1'b1;
        w3  = rf.r_data_writeReg;
      end
      if (done) begin
        lat = n;
        break;
      end
      cyc();
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int          lat;
  bit          busy1;
  logic [31:0] w3;
  int          dcount;
  int          dcyc;
  bit          bhist [0:210];
  int          nf;
  int          rst_at;
  int          fr;
  int          fb;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rf.p_ctrl_writeEnable = 1'b0;
    rf.p_ctrl_writeReg    = '0;
    rf.p_ctrl_readRegA    = '0;
    rf.p_ctrl_readRegB    = '0;
    rf.p_data_writeReg    = '0;
    clear_faults();
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Reset state and pass-through.
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(proc_stall), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_fail", 32'(fail_reg), 32'd0);
    rf.p_ctrl_writeEnable = 1'b1;
    rf.p_ctrl_writeReg    = 5'd7;
    rf.p_data_writeReg    = 32'h1234;
    #1;
    chk("idle_we", 32'(rf.r_ctrl_writeEnable), 32'd1);
    chk("idle_wr", 32'(rf.r_ctrl_writeReg), 32'd7);
    chk("idle_wd", rf.r_data_writeReg, 32'h1234);
    cyc();

    // Good regfile.
    run_test(lat, busy1, w3);
    chk("good_busy_rise", 32'(busy1), 32'd1);
    chk("good_w3", w3, 32'hA5A5_5A59);
    chk("good_latency", 32'(lat), 32'd129);
    chk("good_pass", 32'(pass), 32'd1);
    chk("good_err", 32'(err_count), 32'd0);
    cyc();

    // Reg 9 bit 0 stuck at 1: only pass 1 data has bit 0 clear, on both ports.
    stuck1[9] = 32'h1;
    run_test(lat, busy1, w3);
    chk("stuck_pass", 32'(pass), 32'd0);
    chk("stuck_fail_reg", 32'(fail_reg), 32'd9);
    chk("stuck_err", 32'(err_count), 32'd2);
    cyc();
    clear_faults();

    // All reads zero: reg 31 on port B misses first; count saturates.
    zero_rd = 1'b1;
    run_test(lat, busy1, w3);
    chk("zero_err", 32'(err_count), 32'd63);
    chk("zero_fail_reg", 32'(fail_reg), 32'd31);
    chk("zero_pass", 32'(pass), 32'd0);
    cyc();
    clear_faults();

    // start held high: one test, next one only after a single idle cycle.
    start  = 1'b1;
    dcount = 0;
    dcyc   = -1;
    for (int n = 1; n <= 200; n++) begin
      cyc();
      bhist[n] = busy;
      if (done) begin
        dcount++;
        if (dcyc < 0) dcyc = n;
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(dcount), 32'd1);
    chk("held_done_cycle", 32'(dcyc), 32'd129);
    if (dcyc > 0 && dcyc < 200) begin
      chk("held_idle_gap", 32'(bhist[dcyc+1]), 32'd0);
      chk("held_restart", 32'(bhist[dcyc+2]), 32'd1);
    end
    wait_idle();
    cyc();

    // Reset 40 cycles into a test.
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (39) cyc();
    reset = 1'b1;
    cyc();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(rf.r_ctrl_writeEnable), 32'(rf.p_ctrl_writeEnable));
    chk("mid_rst_wr", 32'(rf.r_ctrl_writeReg), 32'(rf.p_ctrl_writeReg));
    chk("mid_rst_wd", rf.r_data_writeReg, rf.p_data_writeReg);
    chk("mid_rst_pass", 32'(pass), 32'd0);
    reset  = 1'b0;
    dcount = 0;
    for (int n = 0; n < 150; n++) begin
      cyc();
      if (done) dcount++;
    end
    chk("mid_rst_no_done", 32'(dcount), 32'd0);

    // Randomized faults, start activity and occasional mid-test reset.
    for (int t = 0; t < 8; t++) begin
      start = 1'b0;
      reset = 1'b0;
      wait_idle();
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        fr = $urandom_range(0, NUM_REGS - 1);
        fb = $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) stuck1[fr][fb] = 1'b1;
        else                           stuck0[fr][fb] = 1'b1;
      end
      zero_rd = ($urandom_range(0, 7) == 0);
      rst_at  = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 120) : -1;
      for (int n = 0; n < TEST_LEN + 20; n++) begin
        start = (n == 0) || ($urandom_range(0, 5) == 0);
        reset = (n == rst_at);
        cyc();
      end
    end
    start = 1'b0;
    reset = 1'b0;
    wait_idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
